// File: rtl/if_axi_rd_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : if_axi_rd_bridge_pkg                                            |
// | Shared encodings for the fetch-side AXI4 read bridge: transfer sizes,     |
// | AXI burst/resp/prot codes, FSM states and the size alignment helper.      |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package if_axi_rd_bridge_pkg;

   localparam logic [1:0] SIZE_B          = 2'd0;
   localparam logic [1:0] SIZE_H          = 2'd1;
   localparam logic [1:0] SIZE_W          = 2'd2;
   localparam logic [1:0] SIZE_D          = 2'd3;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Instruction fetch, secure, unprivileged
   localparam logic [2:0] AXI_PROT_INST   = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DONE = 2'd3
   } rd_state_t;

   // True when the low address bits are a multiple of the transfer size
   function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
      logic ok;
      case (size)
         SIZE_B:  ok = 1'b1;
         SIZE_H:  ok = (addr_lo[0] == 1'b0);
         SIZE_W:  ok = (addr_lo[1:0] == 2'b00);
         default: ok = (addr_lo == 3'b000);
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_rd_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : if_rd_align                                                     |
// | Right-aligns a 64-bit bus word to a byte address and reports whether the |
// | address is naturally aligned to the requested transfer size.             |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module if_rd_align
   import if_axi_rd_bridge_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] i_data,
   input  logic [2:0]        i_addr_lo,
   input  logic [1:0]        i_size,
   output logic [DATA_W-1:0] o_data,
   output logic              o_aligned
);

   // Byte-lane shift and alignment check, purely combinational
   always_comb begin
      o_data    = i_data >> {i_addr_lo, 3'b000};
      o_aligned = is_aligned(i_addr_lo, i_size);
   end

endmodule
`default_nettype wire

// File: rtl/if_axi_rd_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : if_axi_rd_bridge                                                |
// | Fetch-unit to AXI4 read bridge: one single-beat AR/R transaction per     |
// | request, right-aligned read data, misaligned requests answered SLVERR.   |
// | Optional one-line read buffer enabled by macro IF_AXI_LINE_BUF_EN.       |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module if_axi_rd_bridge
   import if_axi_rd_bridge_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'd0,
   parameter int         ADDR_W = 64,
   parameter int         DATA_W = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_user_valid,
   input  logic [ADDR_W-1:0] i_user_addr,
   input  logic [1:0]        i_user_size,
   output logic              o_user_ready,
   output logic [DATA_W-1:0] o_user_data,
   output logic [1:0]        o_user_resp,
   input  logic              i_flush,
   output logic              o_axi_ar_valid,
   input  logic              i_axi_ar_ready,
   output logic [ADDR_W-1:0] o_axi_ar_addr,
   output logic [3:0]        o_axi_ar_id,
   output logic [7:0]        o_axi_ar_len,
   output logic [2:0]        o_axi_ar_size,
   output logic [1:0]        o_axi_ar_burst,
   output logic [2:0]        o_axi_ar_prot,
   input  logic              i_axi_r_valid,
   output logic              o_axi_r_ready,
   input  logic [DATA_W-1:0] i_axi_r_data,
   input  logic [1:0]        i_axi_r_resp,
   input  logic              i_axi_r_last
);

   rd_state_t         r_state;
   rd_state_t         w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;

   logic              w_in_r;
   logic              w_r_beat;
   logic              w_req;
   logic [DATA_W-1:0] w_al_src;
   logic [2:0]        w_al_addr;
   logic [1:0]        w_al_size;
   logic [DATA_W-1:0] w_al_data;
   logic              w_al_ok;
   logic              w_hit;
   logic [DATA_W-1:0] w_buf_data;
   logic              w_unused_ok;

   // One aligner serves both the R beat (latched address) and the IDLE-time
   // request check / buffer hit (live user address)
   always_comb begin
      w_in_r    = (r_state == ST_R);
      w_r_beat  = w_in_r && i_axi_r_valid;
      w_req     = (r_state == ST_IDLE) && i_user_valid;
      w_al_src  = w_in_r ? i_axi_r_data : w_buf_data;
      w_al_addr = w_in_r ? r_addr[2:0]  : i_user_addr[2:0];
      w_al_size = w_in_r ? r_size       : i_user_size;
   end

   if_rd_align #(
      .DATA_W    (DATA_W)
   ) u_align (
      .i_data    (w_al_src),
      .i_addr_lo (w_al_addr),
      .i_size    (w_al_size),
      .o_data    (w_al_data),
      .o_aligned (w_al_ok)
   );

`ifdef IF_AXI_LINE_BUF_EN
   logic              r_lb_valid;
   logic [ADDR_W-1:3] r_lb_tag;
   logic [DATA_W-1:0] r_lb_data;

   // Line buffer: filled by OKAY beats; flush wins over a same-cycle fill
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lb_valid <= 1'b0;
         r_lb_tag   <= '0;
         r_lb_data  <= '0;
      end else if (i_flush) begin
         r_lb_valid <= 1'b0;
      end else if (w_r_beat) begin
         if (i_axi_r_resp == AXI_RESP_OKAY) begin
            r_lb_valid <= 1'b1;
            r_lb_tag   <= r_addr[ADDR_W-1:3];
            r_lb_data  <= i_axi_r_data;
         end else begin
            r_lb_valid <= 1'b0;
         end
      end
   end

   // Hit only for aligned requests; a flush in the same cycle forces a miss
   always_comb begin
      w_buf_data = r_lb_data;
      w_hit      = w_req && w_al_ok && r_lb_valid && !i_flush &&
                   (r_lb_tag == i_user_addr[ADDR_W-1:3]);
   end

   assign w_unused_ok = &{1'b0, i_axi_r_last};
`else
   // No buffer: every aligned request goes out on AXI
   always_comb begin
      w_buf_data = '0;
      w_hit      = 1'b0;
   end

   assign w_unused_ok = &{1'b0, i_axi_r_last, i_flush};
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and state-decoded handshake outputs
   always_comb begin
      w_state_nxt    = r_state;
      o_axi_ar_valid = 1'b0;
      o_axi_r_ready  = 1'b0;
      o_user_ready   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_user_valid) w_state_nxt = (w_al_ok && !w_hit) ? ST_AR : ST_DONE;
         end
         ST_AR: begin
            o_axi_ar_valid = 1'b1;
            if (i_axi_ar_ready) w_state_nxt = ST_R;
         end
         ST_R: begin
            o_axi_r_ready = 1'b1;
            if (i_axi_r_valid) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            o_user_ready = 1'b1;
            w_state_nxt  = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Request latch and completion data; data/resp hold until the next completion
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr <= '0;
         r_size <= SIZE_B;
         r_data <= '0;
         r_resp <= AXI_RESP_OKAY;
      end else begin
         if (w_req) begin
            if (!w_al_ok) begin
               r_data <= '0;
               r_resp <= AXI_RESP_SLVERR;
            end else if (w_hit) begin
               r_data <= w_al_data;
               r_resp <= AXI_RESP_OKAY;
            end else begin
               r_addr <= i_user_addr;
               r_size <= i_user_size;
            end
         end
         if (w_r_beat) begin
            r_data <= w_al_data;
            r_resp <= i_axi_r_resp;
         end
      end
   end

   assign o_user_data    = r_data;
   assign o_user_resp    = r_resp;
   assign o_axi_ar_addr  = r_addr;
   assign o_axi_ar_id    = AXI_ID;
   assign o_axi_ar_len   = 8'd0;
   assign o_axi_ar_size  = {1'b0, r_size};
   assign o_axi_ar_burst = AXI_BURST_INCR;
   assign o_axi_ar_prot  = AXI_PROT_INST;

endmodule
`default_nettype wire

// File: doc/if_axi_rd_bridge.md
Name: if_axi_rd_bridge

Overview:
- Read-only AXI4 master bridge directly upstream of the fetch unit.
- Converts the fetch unit's simple valid/ready request (address and size in, data and response out) into single-beat AXI4 AR/R transactions.
- Right-aligns returned bus data to the request address, so the fetch unit always takes the instruction from data bits [31:0].
- Sits between the fetch stage and the SoC crossbar.

Parameters:
- AXI_ID, 4'd0, constant ARID driven on every request.
- ADDR_W, 64, user and AXI address width.
- DATA_W, 64, user and AXI data width; fixed at 64 in this version.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_user_valid  in  1  fetch request pending (level)
- i_user_addr  in  64  request byte address
- i_user_size  in  2  SIZE_B/H/W/D
- o_user_ready  out  1  one-cycle completion pulse; data/resp valid this cycle
- o_user_data  out  64  right-aligned read data
- o_user_resp  out  2  AXI-coded response
- i_flush  in  1  invalidate line buffer (fence.i); used only with the optional feature
- o_axi_ar_valid  out  1  AR valid
- i_axi_ar_ready  in  1  AR ready
- o_axi_ar_addr  out  64  AR address (unmodified user address)
- o_axi_ar_id  out  4  = AXI_ID
- o_axi_ar_len  out  8  = 0
- o_axi_ar_size  out  3  = {1'b0, size}
- o_axi_ar_burst  out  2  = INCR
- o_axi_ar_prot  out  3  = 3'b100 (instruction, secure, unprivileged)
- i_axi_r_valid  in  1  R valid
- o_axi_r_ready  out  1  R ready
- i_axi_r_data  in  64  R data
- i_axi_r_resp  in  2  R resp
- i_axi_r_last  in  1  ignored (len=0)

Behaviour:
- Reset (i_i_rst=1 at an edge): state IDLE. o_axi_ar_valid=0, o_axi_r_ready=0, o_user_ready=0, o_user_data=0, o_user_resp=OKAY, latched address=0.
- Reset mid-transaction abandons the transaction. The interconnect is reset by the same signal.
- FSM states: IDLE, AR, R, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - If i_user_valid=1 and the address is aligned to its size: latch addr/size, go to AR.
  - If i_user_valid=1 and the address is misaligned: issue no AXI transaction. Set o_user_data=0, o_user_resp=SLVERR, go to DONE.
- AR:
  - o_axi_ar_valid=1, held until i_axi_ar_ready.
  - AR address and size come only from the latched values; user input changes are ignored.
  - On ar_ready, go to R.
- R:
  - o_axi_r_ready=1.
  - On i_axi_r_valid: o_user_data <= i_axi_r_data >> {latched_addr[2:0], 3'b000}; o_user_resp <= i_axi_r_resp; go to DONE.
  - r_ready is never 1 outside R.
- DONE:
  - o_user_ready=1 for exactly this cycle, then go to IDLE.
  - The next request is sampled in IDLE one cycle later. This gives the fetch unit its registered address increment.
- Minimum latency: request sampled at cycle 0, ar_valid at cycle 1, r beat at cycle 2, o_user_ready at cycle 3. Each AXI stall cycle adds one cycle.
- o_user_data/o_user_resp hold their value until the next completion.
- Non-OKAY R responses are passed through unchanged; the bridge does not retry.
- Only one outstanding transaction at a time, so r_id is not checked.

Optional Feature:
- Macro: IF_AXI_LINE_BUF_EN.
- With the macro defined:
  - One-entry line buffer: 64-bit data, tag addr[63:3], valid bit. Filled on every R beat with resp=OKAY.
  - In IDLE, an aligned request whose addr[63:3] matches a valid tag skips AR/R. The bridge shifts the buffered data, sets resp=OKAY and goes to DONE the next cycle (latency 1).
  - The valid bit is cleared by i_rst, by i_flush (which has priority over a same-cycle fill), and by any non-OKAY response.
- Without the macro: no buffer, i_flush is ignored, every aligned request goes through AXI.

Decomposition:
- Shared defines (existing defines.v): SIZE_B/H/W/D, AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_PROT_INST, FSM state encodings.
- One natural sub-module: if_rd_align. Combinational right-shift by addr[2:0] bytes plus size/address alignment check. Shared by the R path and the line-buffer path.

Test Plan:
- Basic fetch: addr 0x8000_0004, SIZE_W, ar_ready=1 immediately, R data 0x1122_3344_5566_7788 OKAY at next cycle -> ar_addr=0x8000_0004, ar_size=3'b010, o_user_ready pulse 3 cycles after request, o_user_data[31:0]=0x1122_3344, resp=OKAY.
- Back-pressure: ar_ready low 4 cycles, r_valid delayed 3 cycles -> ar_valid and ar_addr stable throughout; r_ready=1 only in R; single ready pulse at cycle 3+4+3.
- Misaligned: SIZE_W at 0x8000_0002 -> no ar_valid ever; ready pulse at cycle 1; resp=SLVERR; data=0.
- Error pass-through: R resp=DECERR -> o_user_resp=2'b11; next request proceeds normally.
- Reset mid-R (i_rst asserted while r_ready=1) -> next cycle state IDLE, ar_valid=0, r_ready=0, o_user_ready=0.
- With IF_AXI_LINE_BUF_EN: fetch 0x8000_0000, then 0x8000_0004 -> second completes in 1 cycle with no ar_valid, data=upper word. Assert i_flush, re-fetch 0x8000_0004 -> goes through AXI.
